// File: rtl/rs_pkg.sv
// Shared constants and the entry record for the reservation station pool.
package rs_pkg;

  localparam int unsigned RS_DEPTH_DEF  = 8;
  localparam int unsigned TAG_W_DEF     = 5;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned PAYLOAD_W_DEF = 96;

  // Entry record at the default configuration
  typedef struct packed {
    logic                             busy;
    logic [PAYLOAD_W_DEF-1:0]         payload;
    logic [TAG_W_DEF-1:0]             tag;
    logic [1:0]                       src_rdy;
    logic [1:0][TAG_W_DEF-1:0]        src_tag;
    logic [1:0][DATA_W_DEF-1:0]       src_val;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix for the reservation station pool; grants the oldest eligible entry.
// older_q[i][j] set means entry j was allocated before entry i.
module rs_age_matrix #(
  parameter int unsigned DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] clear,
  input  logic [DEPTH-1:0] busy,
  input  logic [DEPTH-1:0] elig,
  output logic [DEPTH-1:0] grant_c
);

  logic [DEPTH-1:0] older_q [DEPTH];

  // New row snapshots live entries; freed or reused columns are wiped
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int i = 0; i < int'(DEPTH); i++) older_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        for (int j = 0; j < int'(DEPTH); j++) begin
          if (alloc[i])
            older_q[i][j] <= busy[j] & ~clear[j];
          else if (alloc[j] | clear[j])
            older_q[i][j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    grant_c = '0;
    for (int i = 0; i < int'(DEPTH); i++)
      grant_c[i] = elig[i] & ~(|(older_q[i] & elig));
  end

endmodule

// File: rtl/rs_pool.sv
// Age-ordered reservation station pool with CDB wakeup and valid/ready issue.
// Define RS_AGE_ORDER_EN for oldest-first selection; otherwise lowest index wins.
module rs_pool
  import rs_pkg::*;
#(
  parameter int unsigned RS_DEPTH  = RS_DEPTH_DEF,
  parameter int unsigned TAG_W     = TAG_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned PAYLOAD_W = PAYLOAD_W_DEF
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           dp_valid,
  output logic                           dp_ready,
  input  logic [PAYLOAD_W-1:0]           dp_payload,
  input  logic [TAG_W-1:0]               dp_tag,
  input  logic [1:0]                     dp_src_rdy,
  input  logic [2*TAG_W-1:0]             dp_src_tag,
  input  logic [2*DATA_W-1:0]            dp_src_val,
  input  logic                           cdb_valid,
  input  logic [TAG_W-1:0]               cdb_tag,
  input  logic [DATA_W-1:0]              cdb_value,
  output logic                           is_valid,
  input  logic                           is_ready,
  output logic [PAYLOAD_W-1:0]           is_payload,
  output logic [TAG_W-1:0]               is_tag,
  output logic [DATA_W-1:0]              is_src1,
  output logic [DATA_W-1:0]              is_src2,
  output logic [$clog2(RS_DEPTH+1)-1:0]  free_count
);

  localparam int unsigned FC_W = $clog2(RS_DEPTH + 1);

  logic [RS_DEPTH-1:0]  busy_q;
  logic [PAYLOAD_W-1:0] payload_q [RS_DEPTH];
  logic [TAG_W-1:0]     tag_q     [RS_DEPTH];
  logic [1:0]           src_rdy_q [RS_DEPTH];
  logic [TAG_W-1:0]     src_tag_q [RS_DEPTH][2];
  logic [DATA_W-1:0]    src_val_q [RS_DEPTH][2];

  logic [RS_DEPTH-1:0]  alloc_oh, elig, grant, issue_oh;
  logic                 alloc_found;
  logic                 do_alloc, do_issue;
  logic [1:0]           new_rdy;
  logic [DATA_W-1:0]    new_val [2];

  assign dp_ready = ~&busy_q;
  assign do_alloc = dp_valid & dp_ready;
  assign is_valid = |elig;
  assign do_issue = is_valid & is_ready;
  assign issue_oh = grant & {RS_DEPTH{is_ready}};

  // Lowest-index free entry
  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      if (!busy_q[i] && !alloc_found) begin
        alloc_oh[i] = dp_valid;
        alloc_found = 1'b1;
      end
    end
  end

  // Catch a broadcast that coincides with dispatch
  always_comb begin
    new_rdy = '0;
    for (int s = 0; s < 2; s++) begin
      new_rdy[s] = dp_src_rdy[s] |
                   (cdb_valid & (dp_src_tag[s*TAG_W +: TAG_W] == cdb_tag));
      new_val[s] = dp_src_rdy[s] ? dp_src_val[s*DATA_W +: DATA_W] : cdb_value;
    end
  end

  always_comb begin
    elig = '0;
    for (int i = 0; i < int'(RS_DEPTH); i++)
      elig[i] = busy_q[i] & (&src_rdy_q[i]);
  end

`ifdef RS_AGE_ORDER_EN
  rs_age_matrix #(.DEPTH(RS_DEPTH)) u_age (
    .clock   (clock),
    .reset   (reset),
    .flush   (flush),
    .alloc   (alloc_oh),
    .clear   (issue_oh),
    .busy    (busy_q),
    .elig    (elig),
    .grant_c (grant)
  );
`else
  logic grant_found;

  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      if (elig[i] && !grant_found) begin
        grant[i]    = 1'b1;
        grant_found = 1'b1;
      end
    end
  end
`endif

  // One-hot OR mux; all zero when nothing is eligible
  always_comb begin
    is_payload = '0;
    is_tag     = '0;
    is_src1    = '0;
    is_src2    = '0;
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      if (grant[i]) begin
        is_payload = is_payload | payload_q[i];
        is_tag     = is_tag | tag_q[i];
        is_src1    = is_src1 | src_val_q[i][0];
        is_src2    = is_src2 | src_val_q[i][1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      busy_q     <= '0;
      free_count <= FC_W'(RS_DEPTH);
    end else begin
      busy_q <= (busy_q | alloc_oh) & ~issue_oh;
      if (do_alloc && !do_issue)
        free_count <= free_count - FC_W'(1);
      else if (!do_alloc && do_issue)
        free_count <= free_count + FC_W'(1);
    end
  end

  // Entry datapath; validity is carried solely by busy_q
  always_ff @(posedge clock) begin
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      if (alloc_oh[i]) begin
        payload_q[i] <= dp_payload;
        tag_q[i]     <= dp_tag;
        src_rdy_q[i] <= new_rdy;
        for (int s = 0; s < 2; s++) begin
          src_tag_q[i][s] <= dp_src_tag[s*TAG_W +: TAG_W];
          src_val_q[i][s] <= new_val[s];
        end
      end else begin
        for (int s = 0; s < 2; s++) begin
          if (busy_q[i] && !src_rdy_q[i][s] && cdb_valid && (src_tag_q[i][s] == cdb_tag)) begin
            src_rdy_q[i][s] <= 1'b1;
            src_val_q[i][s] <= cdb_value;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_pool.sv
// Scoreboard bench for rs_pool: issued entries are matched against a queue of expectations.
module tb_rs_pool;

  localparam int unsigned TW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned PW = 96;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          dp_valid = 1'b0;
  logic          dp_ready;
  logic [PW-1:0] dp_payload = '0;
  logic [TW-1:0] dp_tag = '0;
  logic [1:0]    dp_src_rdy = '0;
  logic [2*TW-1:0] dp_src_tag = '0;
  logic [2*DW-1:0] dp_src_val = '0;
  logic          cdb_valid = 1'b0;
  logic [TW-1:0] cdb_tag = '0;
  logic [DW-1:0] cdb_value = '0;
  logic          is_valid;
  logic          is_ready = 1'b0;
  logic [PW-1:0] is_payload;
  logic [TW-1:0] is_tag;
  logic [DW-1:0] is_src1, is_src2;
  logic [3:0]    free_count;

  rs_pool dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .dp_valid   (dp_valid),
    .dp_ready   (dp_ready),
    .dp_payload (dp_payload),
    .dp_tag     (dp_tag),
    .dp_src_rdy (dp_src_rdy),
    .dp_src_tag (dp_src_tag),
    .dp_src_val (dp_src_val),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_value  (cdb_value),
    .is_valid   (is_valid),
    .is_ready   (is_ready),
    .is_payload (is_payload),
    .is_tag     (is_tag),
    .is_src1    (is_src1),
    .is_src2    (is_src2),
    .free_count (free_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] s1;
    logic [DW-1:0] s2;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic logic [PW-1:0] pl(input logic [TW-1:0] t);
    return {32'hC0DE_0000 | 32'(t), 32'h1234_5678, 32'hFEED_0000 | 32'(t)};
  endfunction

  task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dp_valid  = 1'b0;
    cdb_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic set_dp(input logic [TW-1:0] t, input logic [1:0] rdy,
                        input logic [TW-1:0] t1, input logic [TW-1:0] t2,
                        input logic [DW-1:0] v1, input logic [DW-1:0] v2);
    dp_valid   = 1'b1;
    dp_tag     = t;
    dp_payload = pl(t);
    dp_src_rdy = rdy;
    dp_src_tag = {t2, t1};
    dp_src_val = {v2, v1};
  endtask

  task automatic push(input logic [TW-1:0] t, input logic [DW-1:0] s1, input logic [DW-1:0] s2);
    exp_t e;
    e.tag = t;
    e.s1  = s1;
    e.s2  = s2;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    is_ready = 1'b1;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", 96'(sb.size()), 96'(0));
    if (sb.size() != 0) sb.delete();
    is_ready = 1'b0;
  endtask

  // Every accepted issue must match the head of the scoreboard
  always @(negedge clock) begin
    if (!reset && !flush && is_valid && is_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_issue", 96'(is_tag), 96'(0));
        check("unexpected_issue_valid", 96'(1), 96'(0));
      end else begin
        mon_e = sb.pop_front();
        check("is_tag", 96'(is_tag), 96'(mon_e.tag));
        check("is_src1", 96'(is_src1), 96'(mon_e.s1));
        check("is_src2", 96'(is_src2), 96'(mon_e.s2));
        check("is_payload", is_payload, pl(mon_e.tag));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    reset = 1'b0;

    for (int c = 0; c < 3; c++) begin
      check("rst_free", 96'(free_count), 96'(8));
      check("rst_dp_ready", 96'(dp_ready), 96'(1));
      check("rst_is_valid", 96'(is_valid), 96'(0));
      check("rst_is_tag", 96'(is_tag), 96'(0));
      tick();
    end

    // Wakeup through the CDB after dispatch
    set_dp(5'd3, 2'b10, 5'd5, 5'd0, 32'h0, 32'h10);
    tick(); idle();
    check("a_not_ready", 96'(is_valid), 96'(0));
    check("a_free", 96'(free_count), 96'(7));
    cdb_valid = 1'b1; cdb_tag = 5'd6; cdb_value = 32'hDEAD;
    tick(); cdb_valid = 1'b0;
    check("a_wrong_tag", 96'(is_valid), 96'(0));
    cdb_valid = 1'b1; cdb_tag = 5'd5; cdb_value = 32'hABCD;
    tick(); cdb_valid = 1'b0;
    check("a_valid", 96'(is_valid), 96'(1));
    check("a_tag", 96'(is_tag), 96'(3));
    check("a_src1", 96'(is_src1), 96'(32'hABCD));
    check("a_src2", 96'(is_src2), 96'(32'h10));
    tick();
    check("a_hold_tag", 96'(is_tag), 96'(3));
    push(5'd3, 32'hABCD, 32'h10);
    drain(10);
    check("a_free_after", 96'(free_count), 96'(8));
    check("a_idle_after", 96'(is_valid), 96'(0));

    // Broadcast coinciding with dispatch
    set_dp(5'd4, 2'b10, 5'd7, 5'd0, 32'h0, 32'h22);
    cdb_valid = 1'b1; cdb_tag = 5'd7; cdb_value = 32'h55;
    tick(); idle();
    check("b_valid", 96'(is_valid), 96'(1));
    check("b_src1", 96'(is_src1), 96'(32'h55));
    push(5'd4, 32'h55, 32'h22);
    drain(10);

    // Fill the pool, drop a ninth dispatch, then free one entry
    for (int i = 0; i < 8; i++) begin
      set_dp(TW'(10 + i), 2'b11, 5'd0, 5'd0, DW'(i), DW'(100 + i));
      push(TW'(10 + i), DW'(i), DW'(100 + i));
      tick();
    end
    idle();
    check("c_dp_ready_full", 96'(dp_ready), 96'(0));
    check("c_free_full", 96'(free_count), 96'(0));
    check("c_sel_first", 96'(is_tag), 96'(10));
    set_dp(5'd31, 2'b11, 5'd0, 5'd0, 32'h1, 32'h1);
    tick(); idle();
    check("c_ninth_dropped", 96'(free_count), 96'(0));
    is_ready = 1'b1;
    tick();
    is_ready = 1'b0;
    check("c_free_one", 96'(free_count), 96'(1));
    check("c_dp_ready_one", 96'(dp_ready), 96'(1));
    drain(20);
    check("c_free_drained", 96'(free_count), 96'(8));

    // Selection order after an entry is reused
    set_dp(5'd20, 2'b11, 5'd0, 5'd0, 32'hA0, 32'hA1); push(5'd20, 32'hA0, 32'hA1); tick();
    set_dp(5'd21, 2'b11, 5'd0, 5'd0, 32'hB0, 32'hB1); tick();
    set_dp(5'd22, 2'b11, 5'd0, 5'd0, 32'hC0, 32'hC1); tick();
    idle();
    is_ready = 1'b1;
    tick();
    is_ready = 1'b0;
    set_dp(5'd23, 2'b11, 5'd0, 5'd0, 32'hD0, 32'hD1);
    tick(); idle();
`ifdef RS_AGE_ORDER_EN
    push(5'd21, 32'hB0, 32'hB1);
    push(5'd22, 32'hC0, 32'hC1);
    push(5'd23, 32'hD0, 32'hD1);
`else
    push(5'd23, 32'hD0, 32'hD1);
    push(5'd21, 32'hB0, 32'hB1);
    push(5'd22, 32'hC0, 32'hC1);
`endif
    drain(10);

    // Flush beats same-cycle dispatch and issue
    for (int i = 0; i < 4; i++) begin
      set_dp(TW'(24 + i), 2'b00, 5'd9, 5'd9, 32'h0, 32'h0);
      tick();
    end
    set_dp(5'd28, 2'b11, 5'd0, 5'd0, 32'hE0, 32'hE1);
    tick(); idle();
    check("e_free_before", 96'(free_count), 96'(3));
    check("e_valid_before", 96'(is_valid), 96'(1));
    check("e_tag_before", 96'(is_tag), 96'(28));
    flush = 1'b1;
    set_dp(5'd29, 2'b11, 5'd0, 5'd0, 32'hF0, 32'hF1);
    is_ready = 1'b1;
    tick(); idle();
    check("e_free_flush", 96'(free_count), 96'(8));
    check("e_valid_flush", 96'(is_valid), 96'(0));
    check("e_dp_ready_flush", 96'(dp_ready), 96'(1));
    cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_value = 32'h99;
    tick(); cdb_valid = 1'b0;
    check("e_no_wake", 96'(is_valid), 96'(0));
    check("e_free_no_wake", 96'(free_count), 96'(8));
    is_ready = 1'b0;

    // Pool works normally after a flush
    set_dp(5'd1, 2'b11, 5'd0, 5'd0, 32'h77, 32'h88);
    push(5'd1, 32'h77, 32'h88);
    tick(); idle();
    drain(10);
    check("sb_empty", 96'(sb.size()), 96'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
